// File: rtl/xbus_pkg.sv
// xbus slave memory shared definitions: FSM state encoding, the
// out-of-range read pattern and the wait-state LFSR constants used
// when XBS_RANDOM_WAIT_EN is defined.
package xbus_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GNT      = 3'd1,
        S_WAIT_SEL = 3'd2,
        S_WAIT     = 3'd3,
        S_ACK      = 3'd4
    } xbs_state_t;

    // Returned on reads that fall outside the RAM window
    localparam logic [31:0] XBS_BAD_DATA  = 32'hDEAD_BEEF;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] XBS_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] XBS_LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/xbs_ram.sv
// Single-port word RAM for the xbus slave: synchronous byte-enabled
// write, combinational read of the addressed word. Contents are never
// reset.
module xbs_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Byte-lane write; lanes with be=0 keep their old contents
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/xbus_slave_mem.sv
// xbus responder with local RAM: grants a single master, captures the
// address phase, inserts wait states and acks the transfer. Outputs are
// registered copies of the FSM state, so gnt/ack appear one cycle after
// the S_GNT/S_ACK state is entered.
// Optional macro XBS_RANDOM_WAIT_EN: wait count taken from a free-running
// LFSR instead of C_WAIT_CYCLES.
module xbus_slave_mem
    import xbus_pkg::*;
#(
    parameter logic [31:0] C_BASE_ADDR   = 32'h0000_0000,
    parameter int          C_DEPTH_LOG2  = 10,
    parameter int          C_WAIT_CYCLES = 2,
    parameter int          C_SEL_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ma_req,
    output logic        xbm_gnt,
    input  logic        ma_select,
    input  logic [31:0] ma_addr,
    input  logic [31:0] ma_data,
    input  logic        ma_rnw,
    input  logic [3:0]  ma_be,
    output logic        xbm_ack,
    output logic [31:0] xbm_data
);

    localparam logic [32:0] WIN_BYTES = 33'd4 << C_DEPTH_LOG2;
    localparam logic [15:0] TMO_LAST  = 16'(C_SEL_TIMEOUT - 1);

    xbs_state_t state, state_nxt;
    logic [15:0] tcnt;
    logic [3:0]  wcnt;
    logic [3:0]  wait_load;

    logic [31:0] cap_addr;
    logic [31:0] cap_data;
    logic        cap_rnw;
    logic [3:0]  cap_be;

    logic [32:0]             cap_off;
    logic                    in_range;
    logic [C_DEPTH_LOG2-1:0] word_idx;
    logic                    ram_we;
    logic [31:0]             ram_rdata;

    logic capture;
    assign capture = (state == S_WAIT_SEL) && ma_select;

`ifdef XBS_RANDOM_WAIT_EN
    logic [15:0] lfsr;

    // Free-running LFSR; its low nibble becomes the wait count at capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr <= XBS_LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], ^(lfsr & XBS_LFSR_TAPS)};
        end
    end

    assign wait_load = lfsr[3:0];
`else
    assign wait_load = 4'(C_WAIT_CYCLES);
`endif

    // Window decode: addresses below the base wrap to a huge offset and fail
    assign cap_off  = {1'b0, cap_addr} - {1'b0, C_BASE_ADDR};
    assign in_range = (cap_off < WIN_BYTES);
    assign word_idx = C_DEPTH_LOG2'(cap_off >> 2);
    assign ram_we   = (state == S_ACK) && !cap_rnw && in_range;

    xbs_ram #(
        .DEPTH_LOG2 (C_DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (cap_be),
        .addr  (word_idx),
        .wdata (cap_data),
        .rdata (ram_rdata)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (ma_req) state_nxt = S_GNT;
            S_GNT:      state_nxt = S_WAIT_SEL;
            S_WAIT_SEL: begin
                if (ma_select) begin
                    state_nxt = S_WAIT;
                end else if (tcnt == TMO_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT:     if (wcnt == 4'd0) state_nxt = S_ACK;
            S_ACK:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Select timeout and wait-state counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tcnt <= '0;
            wcnt <= '0;
        end else begin
            tcnt <= ((state == S_WAIT_SEL) && !ma_select) ? tcnt + 16'd1 : 16'd0;
            if (capture) begin
                wcnt <= wait_load;
            end else if ((state == S_WAIT) && (wcnt != 4'd0)) begin
                wcnt <= wcnt - 4'd1;
            end
        end
    end

    // Hold the master's address phase so later changes cannot disturb it
    always_ff @(posedge clk) begin
        if (capture) begin
            cap_addr <= ma_addr;
            cap_data <= ma_data;
            cap_rnw  <= ma_rnw;
            cap_be   <= ma_be;
        end
    end

    // Registered bus outputs; read data is driven only alongside ack
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            xbm_gnt  <= 1'b0;
            xbm_ack  <= 1'b0;
            xbm_data <= '0;
        end else begin
            xbm_gnt  <= (state == S_GNT);
            xbm_ack  <= (state == S_ACK);
            if ((state == S_ACK) && cap_rnw) begin
                xbm_data <= in_range ? ram_rdata : XBS_BAD_DATA;
            end else begin
                xbm_data <= '0;
            end
        end
    end

endmodule

// File: doc/xbus_slave_mem.md
Name: xbus_slave_mem

Overview:
- Synthesizable xbus responder for a single xbus master such as the prodcons memory-traffic thread.
- Grants the master's request, decodes the address phase, inserts wait states, then acks the transfer.
- Reads and writes a word-addressed, byte-enabled local RAM.
- Replaces the behavioural memory model in XDRS bench builds and closes the master handshake.

Parameters:
- C_BASE_ADDR, 32'h0000_0000, byte base address of the RAM window.
- C_DEPTH_LOG2, 10, log2 of the RAM depth in 32-bit words.
- C_WAIT_CYCLES, 2, wait cycles between address capture and ack (0..15).
- C_SEL_TIMEOUT, 16, cycles in S_WAIT_SEL without ma_select before abandoning the grant.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- ma_req  in  1  master bus request.
- xbm_gnt  out  1  grant, one-cycle pulse.
- ma_select  in  1  master address/data phase valid.
- ma_addr  in  32  byte address.
- ma_data  in  32  write data.
- ma_rnw  in  1  1=read, 0=write.
- ma_be  in  4  byte enables; bit i covers bits 8i+7:8i.
- xbm_ack  out  1  transfer done, one-cycle pulse.
- xbm_data  out  32  read data, valid only while xbm_ack=1.

Behaviour:
- Reset (async, rstn=0):
  - xbm_gnt=0, xbm_ack=0, xbm_data=0.
  - FSM goes to S_IDLE; wait/timeout counters clear.
  - RAM contents are not cleared.
  - Reset mid-transfer abandons the transfer with no ack; any pending write is dropped.
- All outputs are registered.
- FSM states, one transition per posedge:
  - S_IDLE: ma_req=1 -> S_GNT.
  - S_GNT: xbm_gnt=1 for exactly this cycle -> S_WAIT_SEL.
  - S_WAIT_SEL:
    - ma_select=1 -> capture addr/data/rnw/be, load wait counter with C_WAIT_CYCLES, go to S_WAIT.
    - Otherwise the timeout counter increments; at C_SEL_TIMEOUT -> S_IDLE with no ack.
  - S_WAIT: wait counter decrements; when it is 0 -> S_ACK.
    - With C_WAIT_CYCLES=0, S_WAIT lasts one cycle.
  - S_ACK: xbm_ack=1 for exactly this cycle.
    - Read: xbm_data = RAM word.
    - Write: xbm_data=0, RAM updated at this edge under ma_be.
    - -> S_IDLE.
- Latency, edge counting:
  - req sampled high at edge N -> gnt high N+1..N+2.
  - Master's select sampled at N+2 -> ack high for one cycle starting N+4+C_WAIT_CYCLES.
- Address decode:
  - In range means C_BASE_ADDR <= addr < C_BASE_ADDR + 4*2^C_DEPTH_LOG2.
  - Word index = (addr - C_BASE_ADDR)[C_DEPTH_LOG2+1:2]; addr[1:0] is ignored.
- Out-of-range access:
  - Still acked, so the master never deadlocks.
  - Read returns XBS_BAD_DATA=32'hDEAD_BEEF; write is discarded.
- ma_be=4'h0 on a write is a no-op but is still acked. Reads ignore ma_be and return the full word.
- ma_select still high in the cycle after ack is ignored; select is only examined in S_WAIT_SEL.
- ma_req high in S_GNT, S_WAIT_SEL, S_WAIT or S_ACK is ignored. It is re-sampled in S_IDLE, so back-to-back requests get a fresh grant.
- Captured ma_* values are held internally; master changes after capture do not affect the transfer.

Optional Feature:
- Macro: XBS_RANDOM_WAIT_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle.
  - Wait count = LFSR[3:0] captured on entry to S_WAIT; C_WAIT_CYCLES is ignored.
- Undefined: no LFSR logic; fixed C_WAIT_CYCLES.

Decomposition:
- Package xbus_pkg:
  - state enum (S_IDLE, S_GNT, S_WAIT_SEL, S_WAIT, S_ACK).
  - XBS_BAD_DATA.
  - LFSR seed/taps constants.
- Sub-module xbs_ram:
  - Parameterized depth, single port, synchronous write with per-byte enable.
  - Combinational read from the captured word index.

Test Plan:
1. Write 0xCAFE_F00D to 0x10, be=4'hF, then read 0x10 -> second ack returns 0xCAFE_F00D; with C_WAIT_CYCLES=2, ack is 6 edges after req.
2. Write 0x1122_3344 to 0x20, then write 0xAABB_CCDD with be=4'b0101, then read -> 0x11BB_33DD.
3. Read 0x0000_1000 with C_DEPTH_LOG2=10 (out of range) -> ack with 0xDEAD_BEEF. Then write 0x5 to 0x1000 and read 0x0 -> the word at 0x0 is unchanged.
4. Assert req, never assert select -> single gnt pulse, no ack, FSM back in S_IDLE after 16 cycles; the next req is granted normally.
5. Pull rstn low during S_WAIT of a write to 0x30 -> gnt/ack/data go 0 immediately, no ack; a later read of 0x30 returns its prior contents.
6. With XBS_RANDOM_WAIT_EN, run 200 random read/write pairs -> every read matches the scoreboard; observed wait counts span 0..15; every transfer gets exactly one gnt and one ack.
